// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Video timing bundle produced by vga_timing_gen and consumed by the
//   framebuffer / pixel pipeline. Consumers sample every field on the clk
//   edges where pix_stb = 1.
//
//   Valid/ready note: this bundle has no back-pressure. pix_stb plays the
//   role of "valid" and the consumer is always ready. Every other field is
//   meaningful to a consumer only in a cycle where pix_stb is high.
//
//   Signals
//     hsync, vsync   sync levels, polarity set by the generator parameters
//     de             reported pixel lies inside the active area
//     pixel_x/y      active column/row, 0 outside the active area
//     pix_stb        one-clk strobe per pixel
//     line_start     pix_stb-qualified pulse at h = 0
//     frame_start    pix_stb-qualified pulse at h = 0, v = 0
//     vblank_start   pix_stb-qualified pulse at h = 0, v = V_ACTIVE
//     frame_count    completed frames, wraps modulo 2^FC_W
//
//   Modports: master (generator side), slave (consumer side)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CW   = 10,
    parameter int FC_W = 16
);
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [CW-1:0]   pixel_x;
    logic [CW-1:0]   pixel_y;
    logic            pix_stb;
    logic            line_start;
    logic            frame_start;
    logic            vblank_start;
    logic [FC_W-1:0] frame_count;

    modport master (
        output hsync, vsync, de, pixel_x, pixel_y, pix_stb,
               line_start, frame_start, vblank_start, frame_count
    );

    modport slave (
        input  hsync, vsync, de, pixel_x, pixel_y, pix_stb,
               line_start, frame_start, vblank_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA timing generator. A clock-enable divider produces one
//   pixel tick every CLK_DIV clks. Horizontal/vertical counters advance on
//   each tick, and a registered output stage turns the counter values into
//   sync, data-enable, pixel coordinates and per-pixel strobes.
//
//   Ports
//     clk     system clock
//     reset   synchronous, active-high reset (dominates en)
//     en      run enable; 0 freezes divider, counters and level outputs
//     vid     vga_timing_gen_if.master timing bundle
//
//   Timing: the outputs describe the pixel at counter value (h, v) one clk
//   after the tick that consumes that pixel. Strobes are tick-qualified.
//   Level outputs only update while en = 1, so they hold during a pause.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE   = 320,
    parameter int H_FP       = 8,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 40,
    parameter int V_ACTIVE   = 240,
    parameter int V_FP       = 2,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 25,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int CW         = 10,
    parameter int FC_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Elaboration-time legality check of the timing configuration.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || CW < 1 || CW > 30 || FC_W < 1 ||
        (1 << CW) <= H_TOTAL || (1 << CW) <= V_TOTAL) begin : g_param_check
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS_C   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS_C   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   h;
    logic [CW-1:0]   v;
    logic [FC_W-1:0] fc;

    logic tick;
    logic h_act;
    logic v_act;
    logic h_in_sync;
    logic v_in_sync;
    logic h_zero;

    // With CLK_DIV = 1 div_cnt never leaves 0, so tick degenerates to en.
    always_comb begin
        tick      = en && (div_cnt == DIV_LAST);
        h_act     = (h < H_ACT_C);
        v_act     = (v < V_ACT_C);
        h_in_sync = (h >= H_SS_C) && (h < H_SE_C);
        v_in_sync = (v >= V_SS_C) && (v < V_SE_C);
        h_zero    = (h == '0);
    end

    // Divider and raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h       <= '0;
            v       <= '0;
            fc      <= '0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
                if (h == H_LAST_C) begin
                    h <= '0;
                    if (v == V_LAST_C) begin
                        v  <= '0;
                        fc <= fc + FC_W'(1);
                    end else begin
                        v <= v + CW'(1);
                    end
                end else begin
                    h <= h + CW'(1);
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Registered output stage, computed from the pre-edge h/v.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.pix_stb      <= 1'b0;
            vid.line_start   <= 1'b0;
            vid.frame_start  <= 1'b0;
            vid.vblank_start <= 1'b0;
            vid.de           <= 1'b0;
            vid.pixel_x      <= '0;
            vid.pixel_y      <= '0;
            vid.hsync        <= ~H_SYNC_POL;
            vid.vsync        <= ~V_SYNC_POL;
        end else begin
            vid.pix_stb      <= tick;
            vid.line_start   <= tick && h_zero;
            vid.frame_start  <= tick && h_zero && (v == '0);
            vid.vblank_start <= tick && h_zero && (v == V_ACT_C);
            // Level outputs freeze while paused so a consumer sees the last
            // reported pixel rather than the already-advanced counters.
            if (en) begin
                vid.de      <= h_act && v_act;
                vid.pixel_x <= h_act ? h : '0;
                vid.pixel_y <= v_act ? v : '0;
                vid.hsync   <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
                vid.vsync   <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
            end
        end
    end

    assign vid.frame_count = fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two generator instances on one clock with shared reset/en:
//     a: 15x8 raster (8/2/3/2, 4/1/2/1), active-low syncs, CLK_DIV=1, FC_W=4
//     b: 12x8 raster (6/1/2/3, 3/2/1/2), active-high syncs, CLK_DIV=3, FC_W=2
//   The reference model counts enabled clks since reset and derives the
//   pixel index, raster position and frame number by plain division.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    // instance a
    localparam int A_HA = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
    localparam int A_VA = 4, A_VFP = 1, A_VS = 2, A_VBP = 1;
    localparam int A_DIV = 1, A_FCW = 4;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
    // instance b
    localparam int B_HA = 6, B_HFP = 1, B_HS = 2, B_HBP = 3;
    localparam int B_VA = 3, B_VFP = 2, B_VS = 1, B_VBP = 2;
    localparam int B_DIV = 3, B_FCW = 2;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
    localparam int CW = 6;

    localparam logic [22:0] A_RST = 23'h600000;  // both syncs idle high
    localparam logic [20:0] B_RST = 21'h000000;  // both syncs idle low

    logic clk;
    logic reset;
    logic en;

    vga_timing_gen_if #(.CW(CW), .FC_W(A_FCW)) a_if ();
    vga_timing_gen_if #(.CW(CW), .FC_W(B_FCW)) b_if ();

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .CLK_DIV(A_DIV), .CW(CW), .FC_W(A_FCW)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en), .vid(a_if.master)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .CLK_DIV(B_DIV), .CW(CW), .FC_W(B_FCW)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en), .vid(b_if.master)
    );

    // Observed bundles: {hsync, vsync, de, x, y, stb, ls, fs, vb, fc}
    logic [22:0] obs_a;
    logic [20:0] obs_b;
    assign obs_a = {a_if.hsync, a_if.vsync, a_if.de, a_if.pixel_x, a_if.pixel_y,
                    a_if.pix_stb, a_if.line_start, a_if.frame_start,
                    a_if.vblank_start, a_if.frame_count};
    assign obs_b = {b_if.hsync, b_if.vsync, b_if.de, b_if.pixel_x, b_if.pixel_y,
                    b_if.pix_stb, b_if.line_start, b_if.frame_start,
                    b_if.vblank_start, b_if.frame_count};

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Level part of the bundle for pixel index t of a raster.
    function automatic logic [14:0] raster_levels(
        input int t, input int ha, input int hfp, input int hs, input int hbp,
        input int va, input int vfp, input int vs, input int vbp,
        input bit hpol, input bit vpol);
        int ht, vt, hh, vv;
        logic hsy, vsy, d;
        logic [5:0] px, py;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        hh  = t % ht;
        vv  = (t / ht) % vt;
        hsy = (hh >= ha + hfp && hh < ha + hfp + hs) ? hpol : ~hpol;
        vsy = (vv >= va + vfp && vv < va + vfp + vs) ? vpol : ~vpol;
        d   = (hh < ha) && (vv < va);
        px  = (hh < ha) ? 6'(hh) : 6'd0;
        py  = (vv < va) ? 6'(vv) : 6'd0;
        return {hsy, vsy, d, px, py};
    endfunction

    logic [22:0] exp_a;
    logic [20:0] exp_b;

    initial begin : model
        int na, nb, t, hh, vv;
        bit tk;
        na = 0;
        nb = 0;
        exp_a = A_RST;
        exp_b = B_RST;
        forever begin
            @(posedge clk);
            if (reset) begin
                na = 0;
                nb = 0;
                exp_a = A_RST;
                exp_b = B_RST;
            end else if (en) begin
                tk = (na % A_DIV) == A_DIV - 1;
                t  = na / A_DIV;
                hh = t % A_HT;
                vv = (t / A_HT) % A_VT;
                na++;
                exp_a = {raster_levels(t, A_HA, A_HFP, A_HS, A_HBP,
                                       A_VA, A_VFP, A_VS, A_VBP, 1'b0, 1'b0),
                         tk, tk && hh == 0, tk && hh == 0 && vv == 0,
                         tk && hh == 0 && vv == A_VA,
                         4'((na / A_DIV) / (A_HT * A_VT))};
                tk = (nb % B_DIV) == B_DIV - 1;
                t  = nb / B_DIV;
                hh = t % B_HT;
                vv = (t / B_HT) % B_VT;
                nb++;
                exp_b = {raster_levels(t, B_HA, B_HFP, B_HS, B_HBP,
                                       B_VA, B_VFP, B_VS, B_VBP, 1'b1, 1'b1),
                         tk, tk && hh == 0, tk && hh == 0 && vv == 0,
                         tk && hh == 0 && vv == B_VA,
                         2'((nb / B_DIV) / (B_HT * B_VT))};
            end else begin
                // paused: levels and frame count hold, strobes drop
                exp_a = {exp_a[22:8], 4'b0, exp_a[3:0]};
                exp_b = {exp_b[20:6], 4'b0, exp_b[1:0]};
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (obs_a !== A_RST) begin
                miscompares++;
                $display("FAIL reset_a cyc=%0d got %h want %h", i, obs_a, A_RST);
            end
            vectors++;
            if (obs_b !== B_RST) begin
                miscompares++;
                $display("FAIL reset_b cyc=%0d got %h want %h", i, obs_b, B_RST);
            end
        end
    endtask

    task automatic test_first_pixel();
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                vectors++;
                if (!(a_if.pix_stb === 1'b1 && a_if.frame_start === 1'b1 &&
                      a_if.line_start === 1'b1 && a_if.de === 1'b1 &&
                      a_if.pixel_x === 6'd0 && a_if.pixel_y === 6'd0)) begin
                    miscompares++;
                    $display("FAIL first_pix_a got %h want stb/fs/ls/de=1 at (0,0)", obs_a);
                end
            end
            vectors++;
            if (b_if.pix_stb !== (i == 3)) begin
                miscompares++;
                $display("FAIL first_stb_b clk=%0d got %b want %b", i, b_if.pix_stb, i == 3);
            end
            vectors++;
            if (obs_a !== exp_a) begin
                miscompares++;
                $display("FAIL model_a first clk=%0d got %h want %h", i, obs_a, exp_a);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                miscompares++;
                $display("FAIL model_b first clk=%0d got %h want %h", i, obs_b, exp_b);
            end
        end
        vectors++;
        if (b_if.frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL first_fs_b got %b want 1", b_if.frame_start);
        end
    endtask

    task automatic test_full_frames();
        logic [1:0] prev_fc;
        bit saw_wrap;
        prev_fc  = b_if.frame_count;
        saw_wrap = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            vectors++;
            if (obs_a !== exp_a) begin
                miscompares++;
                $display("FAIL model_a frames i=%0d got %h want %h", i, obs_a, exp_a);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                miscompares++;
                $display("FAIL model_b frames i=%0d got %h want %h", i, obs_b, exp_b);
            end
            if (prev_fc == 2'd3 && b_if.frame_count == 2'd0) saw_wrap = 1'b1;
            prev_fc = b_if.frame_count;
        end
        vectors++;
        if (saw_wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL fc_wrap_b got no 3->0 wrap want wrap");
        end
    endtask

    task automatic test_en_gap();
        bit found;
        found = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            vectors++;
            if (obs_a !== exp_a) begin
                miscompares++;
                $display("FAIL model_a gap_wait got %h want %h", obs_a, exp_a);
            end
            if (a_if.pix_stb && a_if.de && a_if.pixel_x == 6'd4) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL gap_wait_timeout got none want pixel x=4");
        end
        en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            vectors++;
            if (a_if.pix_stb !== 1'b0 || b_if.pix_stb !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_stb i=%0d got a=%b b=%b want 0", i, a_if.pix_stb, b_if.pix_stb);
            end
            vectors++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                miscompares++;
                $display("FAIL model_gap i=%0d got %h/%h want %h/%h", i, obs_a, obs_b, exp_a, exp_b);
            end
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (!(a_if.pix_stb === 1'b1 && a_if.pixel_x === 6'd5)) begin
            miscompares++;
            $display("FAIL gap_resume_a got stb=%b x=%0d want stb=1 x=5", a_if.pix_stb, a_if.pixel_x);
        end
        vectors++;
        if (obs_b !== exp_b) begin
            miscompares++;
            $display("FAIL model_b resume got %h want %h", obs_b, exp_b);
        end
    endtask

    task automatic test_random_en();
        for (int i = 0; i < 2000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            vectors++;
            if (obs_a !== exp_a) begin
                miscompares++;
                $display("FAIL model_a rand i=%0d got %h want %h", i, obs_a, exp_a);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                miscompares++;
                $display("FAIL model_b rand i=%0d got %h want %h", i, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (a_if.pix_stb && a_if.de && a_if.pixel_y == 6'd2 && a_if.pixel_x == 6'd5)
                found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reset_wait_timeout got none want pixel (5,2)");
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs_a !== A_RST) begin
            miscompares++;
            $display("FAIL mid_reset_a got %h want %h", obs_a, A_RST);
        end
        vectors++;
        if (obs_b !== B_RST) begin
            miscompares++;
            $display("FAIL mid_reset_b got %h want %h", obs_b, B_RST);
        end
        reset = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (i == 1) begin
                vectors++;
                if (!(a_if.pix_stb === 1'b1 && a_if.frame_start === 1'b1 &&
                      a_if.pixel_x === 6'd0 && a_if.pixel_y === 6'd0 &&
                      a_if.frame_count === 4'd0)) begin
                    miscompares++;
                    $display("FAIL restart_a got %h want stb/fs=1 (0,0) fc=0", obs_a);
                end
            end
            vectors++;
            if (obs_a !== exp_a) begin
                miscompares++;
                $display("FAIL model_a restart i=%0d got %h want %h", i, obs_a, exp_a);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                miscompares++;
                $display("FAIL model_b restart i=%0d got %h want %h", i, obs_b, exp_b);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_pixel();
        test_full_frames();
        test_en_gap();
        test_random_en();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 320x240 VGA sync generator.
- Adds configurable porch/sync/active timings, sync polarity, a pixel clock-enable divider, a run/hold enable, a data-enable flag, frame/line/vblank strobes and a frame counter.
- Sits between the system clock and the framebuffer/pixel pipeline; all downstream video logic samples its outputs when pix_stb=1.

Parameters:
- H_ACTIVE, 320, visible pixels per line
- H_FP, 8, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 40, horizontal back porch (pixels)
- V_ACTIVE, 240, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 25, vertical back porch (lines)
- H_SYNC_POL, 0, 0 = hsync active-low, 1 = active-high
- V_SYNC_POL, 0, 0 = vsync active-low, 1 = active-high
- CLK_DIV, 1, clk cycles per pixel; must be >= 1
- CW, 10, width of pixel_x/pixel_y and internal counters; 2^CW must exceed H_TOTAL and V_TOTAL
- FC_W, 16, frame_count width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  run enable; 0 freezes all timing state
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- de  out  1  high when the reported pixel is inside the active area
- pixel_x  out  CW  active column, 0 outside active
- pixel_y  out  CW  active row, 0 outside active
- pix_stb  out  1  one-clk strobe per pixel; all other outputs are valid for consumers when it is high
- line_start  out  1  pix_stb-qualified pulse for h=0
- frame_start  out  1  pix_stb-qualified pulse for h=0, v=0
- vblank_start  out  1  pix_stb-qualified pulse for h=0, v=V_ACTIVE
- frame_count  out  FC_W  completed frames, wraps modulo 2^FC_W

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset (synchronous, dominates en):
  - div_cnt, h, v and frame_count go to 0.
  - pix_stb, de, line_start, frame_start and vblank_start go to 0; pixel_x and pixel_y go to 0.
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL (inactive levels).
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1. tick = en & (div_cnt==CLK_DIV-1). When CLK_DIV=1, tick = en.
- Counters advance only on tick:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 at V_TOTAL-1.
  - On the tick where h=H_TOTAL-1 and v=V_TOTAL-1, frame_count increments, wrapping at 2^FC_W.
- Output register (every clk edge, computed from the pre-edge h/v):
  - pix_stb <= tick.
  - de <= (h<H_ACTIVE) & (v<V_ACTIVE).
  - pixel_x <= h if h<H_ACTIVE, else 0; pixel_y <= v if v<V_ACTIVE, else 0.
  - hsync is active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync is active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - line_start, frame_start and vblank_start are each tick AND their h/v condition, so they are never high when pix_stb=0.
- Latency: outputs reflect the counter value one clk after the tick cycle of that pixel. The first pix_stb after reset release (en=1) occurs CLK_DIV clks later and carries frame_start=1, line_start=1, de=1, pixel (0,0).
- en=0: div_cnt, h, v and frame_count hold. pix_stb and the strobes read 0 from the next edge. Level outputs (sync, de, pixel_x/y) hold their values. Resuming en=1 continues the divider from its held phase.
- Simultaneous reset and en: reset wins.
- Reset mid-line/mid-frame: restarts at (0,0) with div phase 0. No partial strobes are emitted.
- vblank_start never fires when V_ACTIVE=V_TOTAL, which is an illegal configuration. Parameter legality (all porch/sync values >= 1, CLK_DIV >= 1, counter width) is checked by an elaboration-time assertion.

Test Plan:
- Defaults, CLK_DIV=1: release reset -> first pix_stb at clk 1 with frame_start=1, pixel (0,0); line_start every 464 clks; frame_start every 124816 clks (464x269).
- Defaults: observe hsync -> low for h in [328,423] (96 pixels), otherwise high; vsync low for lines 242-243; de=0 at h=320 and at v=240.
- CLK_DIV=2 with 640x480 timing (16/96/48, 10/2/33): pix_stb every 2nd clk; 800x525 pixels per frame; frame_count=3 after 3x840000 clks.
- H_SYNC_POL=1, V_SYNC_POL=1 -> after reset hsync=vsync=0, and both pulse high only during their sync windows.
- Drop en for 37 clks mid-line at h=100 -> no pix_stb during the gap; the next pix_stb reports x=101 with no skipped or duplicated pixel.
- Assert reset at v=150, h=200 -> next edge returns all outputs to reset values; restart reproduces the first-frame sequence; frame_count=0. Set FC_W=2 -> frame_count wraps 3->0.
